// File: rtl/wb_decoder_pkg.sv
// Shared types and helpers for the Wishbone 1-to-N slave decoder.
package wb_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_ERR
    } dec_state_e;

    localparam int unsigned ERR_CNT_W   = 8;
    localparam int unsigned MAX_SLAVES  = 16;
    localparam int unsigned MAX_FIELD_W = 32;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } hit_t;

    // Lowest-numbered slave whose match value equals the address field wins.
    // Table entries are stored in fixed-width MAX_FIELD_W slots, zero-extended.
    function automatic hit_t first_hit(
        input logic [MAX_FIELD_W-1:0]            adr_field,
        input logic [MAX_SLAVES*MAX_FIELD_W-1:0] table_flat,
        input int unsigned                       n_slaves
    );
        hit_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_SLAVES; i++) begin
            if (!r.hit && (i < n_slaves) &&
                (table_flat[i*MAX_FIELD_W +: MAX_FIELD_W] == adr_field)) begin
                r.hit = 1'b1;
                r.idx = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_dec_watchdog.sv
// Watchdog for the decoder: counts enabled cycles and pulses expire on the
// TIMEOUT_CYCLES-th consecutive enabled cycle since the last clear.
module wb_dec_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count of enabled cycles already elapsed; expire fires on the last allowed one.
    always_comb begin
        expire = enable && !clear && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d  = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_slave_decoder.sv
// Wishbone classic 1-master -> N-slave decoder with latched slave select,
// default-slave bus error, watchdog timeout and error capture registers.
module wb_slave_decoder
    import wb_decoder_pkg::*;
#(
    parameter int unsigned N_SLAVES       = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SEL_MSB        = 19,
    parameter int unsigned SEL_LSB        = 8,
    parameter logic [N_SLAVES-1:0][SEL_MSB-SEL_LSB:0] SLAVE_MATCH =
        {12'hE03, 12'hE02, 12'hE01, 12'hE00},
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = 32'hDEADBEEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wbm_cyc_i,
    input  logic                           wbm_stb_i,
    input  logic                           wbm_we_i,
    input  logic [DATA_WIDTH/8-1:0]        wbm_sel_i,
    input  logic [ADDR_WIDTH-1:0]          wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]          wbm_dat_i,
    output logic [DATA_WIDTH-1:0]          wbm_dat_o,
    output logic                           wbm_ack_o,
    output logic                           wbm_err_o,
    output logic [N_SLAVES-1:0]            wbs_cyc_o,
    output logic [N_SLAVES-1:0]            wbs_stb_o,
    output logic                           wbs_we_o,
    output logic [DATA_WIDTH/8-1:0]        wbs_sel_o,
    output logic [ADDR_WIDTH-1:0]          wbs_adr_o,
    output logic [DATA_WIDTH-1:0]          wbs_dat_o,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
    input  logic [N_SLAVES-1:0]            wbs_ack_i,
    output logic [ERR_CNT_W-1:0]           err_count_o,
    output logic [ADDR_WIDTH-1:0]          err_addr_o
);

    localparam int unsigned FIELD_W = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned IDX_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    dec_state_e                      state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [ERR_CNT_W-1:0]            err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]           err_addr_q, err_addr_d;

    logic [MAX_SLAVES*MAX_FIELD_W-1:0] table_flat;
    logic [MAX_FIELD_W-1:0]            adr_field;
    hit_t                              hit;

    logic wd_clear;
    logic wd_enable;
    logic wd_expire;

    assign wbs_we_o    = wbm_we_i;
    assign wbs_sel_o   = wbm_sel_i;
    assign wbs_adr_o   = wbm_adr_i;
    assign wbs_dat_o   = wbm_dat_i;
    assign err_count_o = err_cnt_q;
    assign err_addr_o  = err_addr_q;

    // Address decode against the match table; lowest matching slave wins.
    always_comb begin
        table_flat = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            table_flat[i*MAX_FIELD_W +: FIELD_W] = SLAVE_MATCH[i];
        end
        adr_field = '0;
        adr_field[FIELD_W-1:0] = wbm_adr_i[SEL_MSB:SEL_LSB];
        hit = first_hit(adr_field, table_flat, N_SLAVES);
    end

    // Watchdog runs only while a slave is strobed under a live master cycle.
    assign wd_enable = (state_q == ST_ACTIVE) && wbm_cyc_i;
    assign wd_clear  = !wd_enable;

    wb_dec_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // Next-state, slave strobes, response mux and error capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        wbs_cyc_o  = '0;
        wbs_stb_o  = '0;
        wbm_ack_o  = 1'b0;
        wbm_err_o  = 1'b0;
        wbm_dat_o  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    idx_d   = hit.hit ? hit.idx[IDX_W-1:0] : '0;
                    state_d = hit.hit ? ST_ACTIVE : ST_ERR;
                end
            end
            ST_ACTIVE: begin
                if (!wbm_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    wbs_cyc_o[idx_q] = 1'b1;
                    wbs_stb_o[idx_q] = 1'b1;
                    wbm_ack_o        = wbs_ack_i[idx_q];
                    wbm_dat_o        = wbs_dat_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
                    // Ack is tested before expire so a same-cycle ack wins.
                    if (wbs_ack_i[idx_q]) begin
                        state_d = ST_IDLE;
                    end else if (wd_expire) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                if (wbm_cyc_i) begin
                    wbm_err_o  = 1'b1;
                    wbm_dat_o  = DEFAULT_DATA;
                    err_addr_d = wbm_adr_i;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched slave index and error capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Scoreboard bench for wb_slave_decoder: stimulus pushes the expected master
// response (cycle, kind, data) into a queue, a negedge monitor pops and checks.
module tb_wb_slave_decoder;

    localparam int          T   = 8;
    localparam logic [31:0] DEF = 32'hDEADBEEF;
    localparam logic [3:0][11:0] DUT_MATCH = {12'hE01, 12'hE02, 12'hE01, 12'hE00};

    // Reference address map: slaves 1 and 3 share a match value.
    logic [11:0] ref_map [4] = '{12'hE00, 12'hE01, 12'hE02, 12'hE01};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wbm_cyc_i, wbm_stb_i, wbm_we_i;
    logic [3:0]   wbm_sel_i;
    logic [31:0]  wbm_adr_i, wbm_dat_i, wbm_dat_o;
    logic         wbm_ack_o, wbm_err_o;
    logic [3:0]   wbs_cyc_o, wbs_stb_o;
    logic         wbs_we_o;
    logic [3:0]   wbs_sel_o;
    logic [31:0]  wbs_adr_o, wbs_dat_o;
    logic [127:0] wbs_dat_i;
    logic [3:0]   wbs_ack_i;
    logic [7:0]   err_count_o;
    logic [31:0]  err_addr_o;

    always #5 clk = ~clk;

    wb_slave_decoder #(
        .N_SLAVES       (4),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .SEL_MSB        (19),
        .SEL_LSB        (8),
        .SLAVE_MATCH    (DUT_MATCH),
        .TIMEOUT_CYCLES (T),
        .DEFAULT_DATA   (DEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wbm_cyc_i   (wbm_cyc_i),
        .wbm_stb_i   (wbm_stb_i),
        .wbm_we_i    (wbm_we_i),
        .wbm_sel_i   (wbm_sel_i),
        .wbm_adr_i   (wbm_adr_i),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_o   (wbm_ack_o),
        .wbm_err_o   (wbm_err_o),
        .wbs_cyc_o   (wbs_cyc_o),
        .wbs_stb_o   (wbs_stb_o),
        .wbs_we_o    (wbs_we_o),
        .wbs_sel_o   (wbs_sel_o),
        .wbs_adr_o   (wbs_adr_o),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_i   (wbs_ack_i),
        .err_count_o (err_count_o),
        .err_addr_o  (err_addr_o)
    );

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q [$];
    resp_t       mon_e;
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc_n = 0;
    logic [3:0]  exp_stb = '0;
    bit          exp_valid = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_eaddr = '0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic int ref_slave(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if (a[19:8] == ref_map[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cyc"},   64'(wbs_cyc_o),   64'd0);
        chk({tag, "_stb"},   64'(wbs_stb_o),   64'd0);
        chk({tag, "_ack"},   64'(wbm_ack_o),   64'd0);
        chk({tag, "_err"},   64'(wbm_err_o),   64'd0);
        chk({tag, "_dat"},   64'(wbm_dat_o),   64'd0);
        chk({tag, "_count"}, 64'(err_count_o), 64'd0);
        chk({tag, "_eaddr"}, 64'(err_addr_o),  64'd0);
    endtask

    // Monitor: protocol invariants, expected strobes, and scoreboard pops.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ack_err_exclusive", 64'(wbm_ack_o & wbm_err_o), 64'd0);
            if (!wbm_cyc_i) chk("resp_outside_cyc", 64'(wbm_ack_o | wbm_err_o), 64'd0);
            chk("bcast_adr", 64'(wbs_adr_o), 64'(wbm_adr_i));
            chk("bcast_dat", 64'(wbs_dat_o), 64'(wbm_dat_i));
            chk("bcast_ctl", 64'({wbs_we_o, wbs_sel_o}), 64'({wbm_we_i, wbm_sel_i}));
            if (exp_valid) begin
                chk("slave_stb", 64'(wbs_stb_o), 64'(exp_stb));
                chk("slave_cyc", 64'(wbs_cyc_o), 64'(exp_stb));
            end
            chk("err_count", 64'(err_count_o), 64'(m_cnt));
            chk("err_addr",  64'(err_addr_o),  64'(m_eaddr));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc_n) begin
                n_vec++;
                n_bad++;
                $display("FAIL missing_resp: expected %s at cycle %0d did not occur",
                         exp_q[0].is_err ? "err" : "ack", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (wbm_ack_o || wbm_err_o) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) begin
                    mon_e = exp_q.pop_front();
                    chk("resp_err",  64'(wbm_err_o), 64'(mon_e.is_err));
                    chk("resp_ack",  64'(wbm_ack_o), 64'(!mon_e.is_err));
                    chk("resp_data", 64'(wbm_dat_o), 64'(mon_e.data));
                end else begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_resp: ack=%0b err=%0b at cycle %0d, none required",
                             wbm_ack_o, wbm_err_o, cyc_n);
                end
            end
        end
    end

    // One master transfer. ack_at/stray_at/drop_at are cycle offsets from the
    // request cycle (0 = never); the expected outcome is derived from the rules.
    task automatic txn(input logic [31:0] adr, input logic [31:0] alt, input bit chg,
                       input bit we, input logic [31:0] rdat, input int ack_at,
                       input int stray, input int stray_at, input int drop_at);
        int          idx, last, c0;
        bit          resp, is_err;
        logic [31:0] sdat [4];
        logic [31:0] a_last;
        resp_t       e;
        idx = ref_slave(adr);
        for (int s = 0; s < 4; s++) sdat[s] = $urandom;
        if (idx >= 0) sdat[idx] = rdat;
        resp = 1'b0; is_err = 1'b0; last = 0; a_last = adr;
        if (drop_at == 1) begin
            last = 1;
        end else if (idx < 0) begin
            resp = 1'b1; is_err = 1'b1; last = 1;
        end else begin
            for (int j = 1; j <= T + 1; j++) begin
                last = j;
                if (drop_at == j) break;
                if (j == T + 1) begin resp = 1'b1; is_err = 1'b1; break; end
                if ((ack_at > 0 && j == ack_at) || (j == stray_at && stray == idx)) begin
                    resp = 1'b1; break;
                end
            end
        end
        c0 = cyc_n;
        if (resp) begin
            e.cyc = c0 + last; e.is_err = is_err; e.data = is_err ? DEF : sdat[idx];
            exp_q.push_back(e);
        end
        for (int j = 0; j <= last; j++) begin
            wbm_cyc_i = !(drop_at != 0 && j >= drop_at);
            wbm_stb_i = wbm_cyc_i;
            wbm_adr_i = (chg && j >= 2) ? alt : adr;
            wbm_we_i  = we;
            wbm_sel_i = 4'($urandom);
            wbm_dat_i = $urandom;
            wbs_dat_i = {sdat[3], sdat[2], sdat[1], sdat[0]};
            wbs_ack_i = '0;
            if (idx >= 0 && ack_at > 0 && j == ack_at) wbs_ack_i[idx] = 1'b1;
            if (stray >= 0 && stray_at > 0 && j == stray_at) wbs_ack_i[stray] = 1'b1;
            exp_valid = wbm_cyc_i;
            exp_stb   = '0;
            if (idx >= 0 && j >= 1 && !(is_err && j == last)) exp_stb[idx] = 1'b1;
            a_last = wbm_adr_i;
            step();
        end
        if (resp && is_err) begin
            m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_eaddr = a_last;
        end
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbs_ack_i = '0;
        exp_stb = '0; exp_valid = 1'b1;
    endtask

    function automatic logic [31:0] mk_adr(input logic [11:0] field);
        logic [31:0] r;
        r = $urandom;
        return {r[31:20], field, r[7:0]};
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int          sel, ack_at, drop_at, stray, stray_at;
        logic [11:0] field;
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_we_i = 1'b0; wbm_sel_i = '0;
        wbm_adr_i = '0; wbm_dat_i = '0; wbs_dat_i = '0; wbs_ack_i = '0;
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();
        exp_valid = 1'b1;

        // Directed cases.
        txn(32'h000E0004, '0, 1'b0, 1'b0, 32'h12345678, 3, -1, 0, 0);
        txn(32'h000FF000, '0, 1'b0, 1'b1, 32'h0, 0, -1, 0, 0);
        txn(32'h000E0100, '0, 1'b0, 1'b0, 32'h0, 0, -1, 0, 0);
        txn(32'h000E0200, '0, 1'b0, 1'b0, 32'hA5A5_0F0F, T, -1, 0, 0);
        txn(32'h000E0010, '0, 1'b0, 1'b0, 32'h0, 0, -1, 0, 3);
        txn(32'h000E0020, '0, 1'b0, 1'b0, 32'hCAFE_F00D, 4, 2, 2, 0);
        txn(32'h000E0000, 32'h000FF0AA, 1'b1, 1'b0, 32'h0, 0, -1, 0, 0);
        txn(32'h000E0300, 32'h000E0000, 1'b1, 1'b1, 32'h0BAD_CAFE, 5, -1, 0, 0);

        // Randomised transfers, some back-to-back.
        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 4);
            if (sel < 3)       field = 12'hE00 + 12'(sel);
            else if (sel == 3) field = 12'hE03;
            else               field = 12'($urandom_range(0, 12'hDFF));
            ack_at   = $urandom_range(1, T + 2);
            drop_at  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, T + 1) : 0;
            stray    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
            stray_at = $urandom_range(1, T);
            txn(mk_adr(field), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, ack_at, stray, stray_at, drop_at);
            repeat ($urandom_range(0, 2)) step();
        end

        // Error counter saturation.
        for (int k = 0; k < 300; k++) begin
            txn(mk_adr(12'($urandom_range(0, 12'hDFF))), '0, 1'b0, 1'b1, 32'h0, 0, -1, 0, 0);
        end
        chk("err_count_saturated", 64'(err_count_o), 64'd255);

        // Asynchronous reset while a slave is strobed.
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_adr_i = 32'h000E0200;
        exp_valid = 1'b0;
        repeat (3) step();
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        m_cnt = 0; m_eaddr = '0;
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        step();
        #2 rst = 1'b0;
        step();
        exp_valid = 1'b1;
        txn(32'h000E0008, '0, 1'b0, 1'b0, 32'h600D_D00D, 2, -1, 0, 0);
        txn(32'h000ABC00, '0, 1'b0, 1'b0, 32'h0, 0, -1, 0, 0);

        repeat (3) step();
        while (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL leftover_resp: expected response at cycle %0d never arrived", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
